// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encoding,
// default operand width and a constant-width helper.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    // Divider control states (2-bit encoding)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    // Ceiling log2, used to size the iteration counter
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One radix-2 restoring step of the divider.
// Shifts the next dividend bit into the partial remainder and conditionally
// subtracts the divisor magnitude.
// Ports:
//   rem        partial remainder (always < divisor)
//   bit_in     next dividend bit, MSB first
//   divisor    divisor magnitude (unsigned, <= 2^(WIDTH-1))
//   rem_next_c new partial remainder (combinational)
//   q_bit_c    quotient bit produced by this step (combinational)
module seq_divider_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Since rem < divisor, a non-negative difference is below 2^WIDTH and a
    // wrapped one is at least 2^WIDTH, so the top bit of diff is the borrow.
    always_comb begin
        shifted    = {rem, bit_in};
        diff       = shifted - {1'b0, divisor};
        q_bit_c    = ~diff[WIDTH];
        rem_next_c = q_bit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed radix-2 restoring divider (2*WIDTH / WIDTH -> WIDTH),
// truncating toward zero; inverse of the signed WIDTHxWIDTH multiplier.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iterations when |A|==0 or |B|==1).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      launch request, sampled only while idle
//   A, B       signed dividend (2*WIDTH) and divisor (WIDTH)
//   Q, R       signed quotient and remainder, registered, held until next done
//   busy       operation in flight
//   done       one-cycle completion pulse
//   ovf        quotient does not fit in WIDTH signed bits (Q=R=0)
//   div_zero   divisor was zero (Q=all ones, R=A[WIDTH-1:0])
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] A,
    input  logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   R,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               div_zero
);

    localparam int unsigned      DW       = 2 * WIDTH;
    localparam int unsigned      CNT_W    = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] HALF     = WIDTH'(1) << (WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [DW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [DW-1:0]    work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             big_q, big_d;

    logic [WIDTH-1:0] q_d, r_d;
    logic             busy_d, done_d, ovf_d, dz_d;

    logic [DW-1:0]    a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag, r_mag;
    logic             q_range_bad;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    // Operand magnitudes; -2^(DW-1) maps to 2^(DW-1) read as unsigned
    assign a_mag = a_q[DW-1] ? (DW'(0) - a_q) : a_q;
    assign b_mag = b_q[WIDTH-1] ? (WIDTH'(0) - b_q) : b_q;

    // {rem, quo} working register: remainder in the upper half, quotient
    // bits shift into the lower half as dividend bits shift out
    assign q_mag = work_q[WIDTH-1:0];
    assign r_mag = work_q[DW-1:WIDTH];

    // A negative quotient may reach -2^(WIDTH-1); a positive one may not
    assign q_range_bad = qneg_q ? (q_mag > HALF) : (q_mag >= HALF);

    seq_divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem        (work_q[DW-1:WIDTH]),
        .bit_in     (work_q[WIDTH-1]),
        .divisor    (bmag_q),
        .rem_next_c (step_rem),
        .q_bit_c    (step_qbit)
    );

    // Next-state and datapath/output update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        bmag_d  = bmag_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        big_d   = big_q;
        q_d     = Q;
        r_d     = R;
        busy_d  = busy;
        done_d  = 1'b0;
        ovf_d   = ovf;
        dz_d    = div_zero;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end

            PREP: begin
                qneg_d = a_q[DW-1] ^ b_q[WIDTH-1];
                rneg_d = a_q[DW-1];
                bmag_d = b_mag;
                zero_d = (b_q == '0);
                // High half >= divisor means the quotient needs more than WIDTH bits
                big_d  = (b_q != '0) && (a_mag[DW-1:WIDTH] >= b_mag);
                work_d = a_mag;
                cnt_d  = '0;
                if ((b_q == '0) || (a_mag[DW-1:WIDTH] >= b_mag)) begin
                    state_d = FIX;
`ifdef DIV_EARLY_OUT_EN
                end else if ((a_mag == '0) || (b_mag == WIDTH'(1))) begin
                    // Trivial quotient: the high half is already zero here
                    work_d  = {WIDTH'(0), a_mag[WIDTH-1:0]};
                    state_d = FIX;
`endif
                end else begin
                    state_d = ITER;
                end
            end

            ITER: begin
                work_d = {step_rem, work_q[WIDTH-2:0], step_qbit};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (zero_q) begin
                    q_d   = '1;
                    r_d   = a_q[WIDTH-1:0];
                    ovf_d = 1'b0;
                    dz_d  = 1'b1;
                end else if (big_q || q_range_bad) begin
                    q_d   = '0;
                    r_d   = '0;
                    ovf_d = 1'b1;
                    dz_d  = 1'b0;
                end else begin
                    q_d   = qneg_q ? (WIDTH'(0) - q_mag) : q_mag;
                    r_d   = rneg_q ? (WIDTH'(0) - r_mag) : r_mag;
                    ovf_d = 1'b0;
                    dz_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            bmag_q   <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            big_q    <= 1'b0;
            Q        <= '0;
            R        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bmag_q   <= bmag_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            zero_q   <= zero_d;
            big_q    <= big_d;
            Q        <= q_d;
            R        <= r_d;
            busy     <= busy_d;
            done     <= done_d;
            ovf      <= ovf_d;
            div_zero <= dz_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, hand-written
// multi-cycle sequences (busy start, mid-run reset) and random operands
// checked against an arithmetic reference model.
module tb_seq_divider;

    localparam int LAT_FULL = 34;
    localparam int LAT_FAST = 2;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_EO = 2;
`else
    localparam int LAT_EO = 34;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        ovf;
        logic        dz;
        int          lat;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        res_t        e;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a_in;
    logic [31:0] b_in;
    logic [31:0] q_out;
    logic [31:0] r_out;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        div_zero;

    int checks;
    int failures;
    vec_t vecs[$];

    seq_divider #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .Q        (q_out),
        .R        (r_out),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: magnitude division with plain arithmetic, then sign rules
    function automatic res_t model(input logic [63:0] a, input logic [31:0] b);
        res_t        e;
        logic [63:0] ma, mb, bs, qm, rm;
        logic        neg;
        e.q = '0; e.r = '0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = LAT_FULL;
        if (b == 32'd0) begin
            e.q = '1; e.r = a[31:0]; e.dz = 1'b1; e.lat = LAT_FAST;
            return e;
        end
        bs  = {{32{b[31]}}, b};
        ma  = a[63] ? (64'd0 - a) : a;
        mb  = b[31] ? (64'd0 - bs) : bs;
        qm  = ma / mb;
        rm  = ma % mb;
        neg = a[63] ^ b[31];
        if (qm >= 64'h1_0000_0000) e.lat = LAT_FAST;
`ifdef DIV_EARLY_OUT_EN
        else if (ma == 64'd0 || mb == 64'd1) e.lat = LAT_FAST;
`endif
        if ((!neg && qm >= 64'h8000_0000) || (neg && qm > 64'h8000_0000)) begin
            e.ovf = 1'b1;
        end else begin
            e.q = neg ? 32'(64'd0 - qm) : 32'(qm);
            e.r = a[63] ? 32'(64'd0 - rm) : 32'(rm);
        end
        return e;
    endfunction

    task automatic add_vec(input logic [63:0] a, input logic [31:0] b, input logic [31:0] q,
                           input logic [31:0] r, input logic o, input logic z, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.e.q = q; v.e.r = r; v.e.ovf = o; v.e.dz = z; v.e.lat = lat;
        vecs.push_back(v);
    endtask

    // Launch one op (start driven in the current/next low phase) and wait for done
    task automatic run_op(input logic [63:0] a, input logic [31:0] b, input string tag, output res_t got);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy_start"}, 64'(busy), 64'd1);
        got.lat = -1; got.q = '0; got.r = '0; got.ovf = 1'b0; got.dz = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got.lat = n; got.q = q_out; got.r = r_out; got.ovf = ovf; got.dz = div_zero;
                break;
            end
        end
        if (got.lat < 0) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout actual=no_done expected=done", tag);
        end else begin
            chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic check_res(input string tag, input res_t got, input res_t e);
        chk({tag, ".Q"},   64'(got.q),   64'(e.q));
        chk({tag, ".R"},   64'(got.r),   64'(e.r));
        chk({tag, ".ovf"}, 64'(got.ovf), 64'(e.ovf));
        chk({tag, ".dz"},  64'(got.dz),  64'(e.dz));
        chk({tag, ".lat"}, 64'(got.lat), 64'(e.lat));
    endtask

    initial begin
        res_t        got;
        res_t        e;
        logic [63:0] a;
        logic [31:0] b, x, y;
        longint      p;
        int          lat;
        int          extra;

        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.Q", 64'(q_out), 64'd0);
        chk("rst.R", 64'(r_out), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        chk("rst.dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors; consecutive ops also start in the previous done cycle
        add_vec(64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, LAT_FULL);
        add_vec(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, LAT_FULL);
        add_vec(64'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, LAT_FULL);
        add_vec(64'hFFFF_FFFF_C962_FC98, 32'hFFFF_FFFD, 32'h1234_5678, 32'd0, 1'b0, 1'b0, LAT_FULL);
        add_vec(64'hFFFF_FFFF_8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, LAT_EO);
        add_vec(64'h0000_0000_8000_0000, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, LAT_EO);
        add_vec(64'h0000_0100_0000_0000, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, LAT_FAST);
        add_vec(64'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, LAT_FAST);
        add_vec(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0, LAT_FAST);
        add_vec(64'hFFFF_FFFF_FFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, LAT_FULL);
        add_vec(64'h0000_0000_7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b0, LAT_EO);
        add_vec(64'hFFFF_FFFF_0000_0000, 32'd2, 32'h8000_0000, 32'd0, 1'b0, 1'b0, LAT_FULL);
        add_vec(64'h4000_0000_0000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b0, LAT_FULL);
        add_vec(64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, LAT_EO);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, LAT_EO);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), got);
            check_res($sformatf("vec%0d", i), got, vecs[i].e);
        end

        // start pulsed mid-run is ignored and not queued; outputs hold after done
        @(negedge clk);
        start = 1'b1; a_in = 64'd100; b_in = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 4) begin start = 1'b1; a_in = 64'd5; b_in = 32'd0; end
            if (n == 5) start = 1'b0;
            if (done) begin lat = n; break; end
        end
        chk("busy_start.lat", 64'(lat), 64'(LAT_FULL));
        chk("busy_start.Q", 64'(q_out), 64'd14);
        chk("busy_start.dz", 64'(div_zero), 64'd0);
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        chk("busy_start.no_queued_op", 64'(extra), 64'd0);
        chk("hold.Q", 64'(q_out), 64'd14);
        chk("hold.R", 64'(r_out), 64'd2);

        // Reset while iterating abandons the op and clears outputs
        @(negedge clk);
        start = 1'b1; a_in = 64'd100; b_in = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst.busy", 64'(busy), 64'd0);
        chk("mid_rst.done", 64'(done), 64'd0);
        chk("mid_rst.Q", 64'(q_out), 64'd0);
        chk("mid_rst.R", 64'(r_out), 64'd0);
        rst = 1'b0;
        e.q = 32'd4; e.r = 32'd1; e.ovf = 1'b0; e.dz = 1'b0; e.lat = LAT_FULL;
        run_op(64'd9, 32'd2, "after_rst", got);
        check_res("after_rst", got, e);

        // Random operands against the reference model
        for (int i = 0; i < 150; i++) begin
            x = $urandom;
            y = $urandom;
            p = longint'($signed(x)) * longint'($signed(y));
            case ($urandom_range(0, 3))
                0: begin a = 64'(p); b = y; end
                1: begin a = 64'(p) + 64'($urandom_range(0, 7)); b = y; end
                2: begin a = {32'($urandom), 32'($urandom)}; b = 32'($urandom); end
                default: begin
                    a = {{32{x[31]}}, x};
                    b = 32'($urandom_range(0, 1000));
                    if (y[0]) b = 32'd0 - b;
                end
            endcase
            e = model(a, b);
            run_op(a, b, $sformatf("rnd%0d", i), got);
            check_res($sformatf("rnd%0d", i), got, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
